// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data port.
// Takes one load/store request at a time and performs the RV32I byte/half/word
// access on a local word array. A programmable number of wait states emulates
// slow memory. Misaligned or illegal requests complete with err=1 and leave
// the array untouched.
module dmem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam bit         NO_WAIT  = (WAIT_CYC == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          wait_cnt;

    logic                req_rd;
    logic                req_wr;
    logic [ADDR_W-1:0]   req_addr;
    logic [2:0]          req_funct3;
    logic [DATA_W-1:0]   req_wr_data;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                cur_rd;
    logic                cur_wr;
    logic [ADDR_W-1:0]   cur_addr;
    logic [2:0]          cur_funct3;
    logic [DATA_W-1:0]   cur_wr_data;

    logic                accept;
    logic                enter_resp;
    logic                misaligned;
    logic                legal_load;
    logic                legal_store;
    logic                req_err;
    logic [ADDR_W-3:0]   word_idx;
    logic [DATA_W-1:0]   rd_word;
    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic [DATA_W-1:0]   load_val;
    logic [DATA_W-1:0]   resp_data;
    logic [3:0]          wr_be;
    logic [DATA_W-1:0]   wr_lanes;
    logic                mem_we;

    // The request being serviced: live inputs while idle (needed when there are
    // no wait states and the access completes on the accept edge), latched copy otherwise
    always_comb begin
        cur_rd      = req_rd;
        cur_wr      = req_wr;
        cur_addr    = req_addr;
        cur_funct3  = req_funct3;
        cur_wr_data = req_wr_data;
        if (state == IDLE) begin
            cur_rd      = rd;
            cur_wr      = wr;
            cur_addr    = addr;
            cur_funct3  = funct3;
            cur_wr_data = wr_data;
        end
    end

    // Decide whether the coming edge accepts a request and whether it enters RESP
    always_comb begin
        accept     = (state == IDLE) && (rd || wr);
        enter_resp = 1'b0;
        if (state == IDLE) begin
            enter_resp = accept && NO_WAIT;
        end else if (state == WAIT) begin
            enter_resp = (wait_cnt == 4'd0);
        end
    end

    // Classify the request: simultaneous rd/wr, bad funct3 or bad alignment is an error
    always_comb begin
        misaligned = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                     ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        case (cur_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_load = 1'b1;
            default:                                legal_load = 1'b0;
        endcase
        case (cur_funct3)
            3'b000, 3'b001, 3'b010: legal_store = 1'b1;
            default:                legal_store = 1'b0;
        endcase
        req_err = (cur_rd && cur_wr) || misaligned ||
                  (cur_rd && !legal_load) || (cur_wr && !legal_store);
    end

    // Load path: pick the addressed lane and sign/zero-extend it
    always_comb begin
        word_idx = cur_addr[ADDR_W-1:2];
        rd_word  = mem[word_idx];
        sel_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
        sel_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_funct3)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, sel_byte};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = '0;
        endcase
        resp_data = (cur_rd && !req_err) ? load_val : '0;
    end

    // Store path: replicate the right-aligned data over all lanes and enable only the addressed ones
    always_comb begin
        case (cur_funct3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << cur_addr[1:0];
                wr_lanes = {4{cur_wr_data[7:0]}};
            end
            2'b01: begin
                wr_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_wr_data[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = cur_wr_data;
            end
        endcase
        mem_we = reset && enter_resp && cur_wr && !req_err;
    end

    // Data array: never cleared by reset; written on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // Request FSM with registered handshake outputs; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            rd_data     <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            req_rd      <= 1'b0;
            req_wr      <= 1'b0;
            req_addr    <= '0;
            req_funct3  <= 3'd0;
            req_wr_data <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_rd      <= rd;
                        req_wr      <= wr;
                        req_addr    <= addr;
                        req_funct3  <= funct3;
                        req_wr_data <= wr_data;
                        busy        <= 1'b1;
                        if (NO_WAIT) begin
                            state   <= RESP;
                            ready   <= 1'b1;
                            err     <= req_err;
                            rd_data <= resp_data;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= RESP;
                        ready   <= 1'b1;
                        err     <= req_err;
                        rd_data <= resp_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with a byte-level
// reference model and a per-cycle compare process.
module tb_dmem_responder;

    localparam int WAIT_CYC = 2;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        rd      = 1'b0;
    logic        wr      = 1'b0;
    logic [8:0]  addr    = '0;
    logic [2:0]  funct3  = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    int          vec_count  = 0;
    int          miss_count = 0;
    resp_t       exp_q[$];
    resp_t       cmp_ex;
    logic [7:0]  model_mem [512];
    logic [31:0] model_rd_data = '0;
    logic        rst_seen      = 1'b0;
    logic [31:0] last_rd_data  = '0;
    logic        last_err      = 1'b0;

    dmem_responder #(
        .DATA_W   (32),
        .ADDR_W   (9),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .funct3  (funct3),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ready   (ready),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, accesses described by size and sign
    function automatic void modelAccess(input logic r, input logic w, input logic [8:0] a,
                                        input logic [2:0] f, input logic [31:0] wd,
                                        output logic e, output logic [31:0] d);
        int              n;
        bit              sgn;
        bit              bad;
        longint unsigned v;
        n = 1; sgn = 0; bad = 0; v = 0;
        e = 1'b0; d = '0;
        if (r && w) begin
            bad = 1;
        end else if (r) begin
            case (f)
                3'b000: begin n = 1; sgn = 1; end
                3'b001: begin n = 2; sgn = 1; end
                3'b010: n = 4;
                3'b100: n = 1;
                3'b101: n = 2;
                default: bad = 1;
            endcase
        end else begin
            case (f)
                3'b000: n = 1;
                3'b001: n = 2;
                3'b010: n = 4;
                default: bad = 1;
            endcase
        end
        if (!bad && ((int'(a) % n) != 0)) bad = 1;
        if (bad) begin
            e = 1'b1;
            return;
        end
        if (w) begin
            for (int i = 0; i < n; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v = v | (64'(model_mem[int'(a) + i]) << (8 * i));
            if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            d = v[31:0];
        end
    endfunction

    // One request from the core side: drive, hold until ready, then release
    task automatic applyStimulus(input logic r, input logic w, input logic [8:0] a,
                                 input logic [2:0] f, input logic [31:0] wd,
                                 input bit toggle, input bit abort);
        resp_t ex;
        int    cycles;
        @(negedge clk);
        rd = r; wr = w; addr = a; funct3 = f; wr_data = wd;
        if (!abort) begin
            modelAccess(r, w, a, f, wd, ex.err, ex.data);
            exp_q.push_back(ex);
        end
        @(posedge clk); #1;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        if (abort) begin
            @(negedge clk);
            reset = 1'b0; rd = 1'b0; wr = 1'b0;
            @(posedge clk); #1;
            checkOutput("abort_ready", 32'(ready), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        cycles = 0;
        while (ready !== 1'b1 && cycles < 20) begin
            if (toggle) begin
                @(negedge clk);
                rd = ~rd; wr = 1'($urandom_range(0, 1));
                addr = 9'($urandom); funct3 = 3'($urandom); wr_data = $urandom;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("ready_latency", 32'(cycles), 32'(WAIT_CYC));
        last_rd_data = rd_data;
        last_err     = err;
        @(posedge clk); #1;
        checkOutput("ready_single_pulse", 32'(ready), 32'd0);
        checkOutput("busy_released", 32'(busy), 32'd0);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
    endtask

    // Per-cycle compare against the model: reset values, responses, and held rd_data
    always begin
        @(posedge clk);
        rst_seen = reset;
        @(negedge clk);
        if (!rst_seen) begin
            model_rd_data = '0;
            checkOutput("reset_ready", 32'(ready), 32'd0);
            checkOutput("reset_busy", 32'(busy), 32'd0);
            checkOutput("reset_err", 32'(err), 32'd0);
            checkOutput("reset_rd_data", rd_data, 32'd0);
        end else if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                cmp_ex = exp_q.pop_front();
                model_rd_data = cmp_ex.data;
                checkOutput("resp_err", 32'(err), 32'(cmp_ex.err));
                checkOutput("resp_rd_data", rd_data, cmp_ex.data);
            end
        end else begin
            checkOutput("idle_err", 32'(err), 32'd0);
            checkOutput("hold_rd_data", rd_data, model_rd_data);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with literal expectations that pin the model
    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_ready", 32'(ready), 32'd0);
        checkOutput("init_busy", 32'(busy), 32'd0);
        checkOutput("init_err", 32'(err), 32'd0);
        checkOutput("init_rd_data", rd_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("idle_no_ready", 32'(ready), 32'd0);
            checkOutput("idle_no_busy", 32'(busy), 32'd0);
        end

        applyStimulus(1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("sw_010_err", 32'(last_err), 32'd0);
        checkOutput("sw_010_rd_data", last_rd_data, 32'd0);
        applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_010_err", 32'(last_err), 32'd0);
        checkOutput("lw_010", last_rd_data, 32'hDEADBEEF);

        applyStimulus(1'b0, 1'b1, 9'h011, 3'b000, 32'h00000080, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'h011, 3'b000, 32'd0, 1'b0, 1'b0);
        checkOutput("lb_011", last_rd_data, 32'hFFFFFF80);
        applyStimulus(1'b1, 1'b0, 9'h011, 3'b100, 32'd0, 1'b0, 1'b0);
        checkOutput("lbu_011", last_rd_data, 32'h00000080);
        applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_010_after_sb", last_rd_data, 32'hDEAD80EF);

        applyStimulus(1'b1, 1'b0, 9'h013, 3'b001, 32'd0, 1'b0, 1'b0);
        checkOutput("lh_013_err", 32'(last_err), 32'd1);
        checkOutput("lh_013_rd_data", last_rd_data, 32'd0);
        applyStimulus(1'b0, 1'b1, 9'h012, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("sw_012_err", 32'(last_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_010_unchanged", last_rd_data, 32'hDEAD80EF);

        applyStimulus(1'b1, 1'b1, 9'h010, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("rdwr_err", 32'(last_err), 32'd1);
        checkOutput("rdwr_rd_data", last_rd_data, 32'd0);
        applyStimulus(1'b1, 1'b0, 9'h010, 3'b011, 32'd0, 1'b0, 1'b0);
        checkOutput("load_f3_011_err", 32'(last_err), 32'd1);
        applyStimulus(1'b0, 1'b1, 9'h010, 3'b100, 32'hFFFFFFFF, 1'b0, 1'b0);
        checkOutput("store_f3_100_err", 32'(last_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_010_after_errs", last_rd_data, 32'hDEAD80EF);

        applyStimulus(1'b0, 1'b1, 9'h014, 3'b010, 32'h11112222, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 9'h016, 3'b001, 32'hABCD9234, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'h016, 3'b001, 32'd0, 1'b0, 1'b0);
        checkOutput("lh_016", last_rd_data, 32'hFFFF9234);
        applyStimulus(1'b1, 1'b0, 9'h016, 3'b101, 32'd0, 1'b0, 1'b0);
        checkOutput("lhu_016", last_rd_data, 32'h00009234);
        applyStimulus(1'b1, 1'b0, 9'h014, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_014", last_rd_data, 32'h92342222);
        applyStimulus(1'b1, 1'b0, 9'h017, 3'b000, 32'd0, 1'b0, 1'b0);
        checkOutput("lb_017", last_rd_data, 32'hFFFFFF92);
        applyStimulus(1'b1, 1'b0, 9'h014, 3'b100, 32'd0, 1'b0, 1'b0);
        checkOutput("lbu_014", last_rd_data, 32'h00000022);

        applyStimulus(1'b1, 1'b0, 9'h014, 3'b010, 32'd0, 1'b1, 1'b0);
        checkOutput("lw_014_toggled", last_rd_data, 32'h92342222);

        applyStimulus(1'b0, 1'b1, 9'h1FC, 3'b010, 32'hA5A55A5A, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'h1FF, 3'b000, 32'd0, 1'b0, 1'b0);
        checkOutput("lb_1ff", last_rd_data, 32'hFFFFFFA5);
        applyStimulus(1'b0, 1'b1, 9'h000, 3'b010, 32'h01020304, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'h003, 3'b100, 32'd0, 1'b0, 1'b0);
        checkOutput("lbu_003", last_rd_data, 32'h00000001);
        applyStimulus(1'b1, 1'b0, 9'h1FC, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_1fc", last_rd_data, 32'hA5A55A5A);

        applyStimulus(1'b0, 1'b1, 9'h020, 3'b010, 32'hCAFEF00D, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 9'h020, 3'b010, 32'h12345678, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 9'h020, 3'b010, 32'd0, 1'b0, 1'b0);
        checkOutput("lw_020_after_abort", last_rd_data, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
